// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback steps.
// Optional JAL support is enabled by defining MULTICYCLE_CTRL_JAL_EN.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        EXEC_I = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        TRAP   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MULTICYCLE_CTRL_JAL_EN
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Unreachable encodings (and JAL when disabled) fall through to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXEC_R;
                    OP_ITYPE:          state_d = EXEC_I;
                    OP_BRANCH:         state_d = BRANCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
                    OP_JAL:            state_d = JAL;
`endif
                    default:           state_d = TRAP;
                endcase
            end
            MEMADR: state_d = (opcode == OP_STORE) ? MEMWR : MEMRD;
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
            EXEC_R: state_d = ALUWB;
            EXEC_I: state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
            JAL:    state_d = FETCH;
`endif
            TRAP:   state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            DECODE: alu_src_b = 2'b10;
            MEMADR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
            end
            EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = 2'b01;
                alu_op     = 2'b01;
                pc_src     = 1'b1;
                pc_write   = zero;
                instr_done = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_JAL_EN
            JAL: begin
                alu_src_b  = 2'b11;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                instr_done = 1'b1;
            end
`endif
            TRAP:    illegal = 1'b1;
            default: ;
        endcase
        // Reset masks every side-effecting strobe in the same cycle.
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, corner sequences, random vs model.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic [3:0] state;
    logic       instr_done, illegal;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // key bits: pc_write, pc_src, mem_write, reg_write, mem_to_reg, instr_done, illegal
    logic [6:0]  key;
    logic [19:0] act_all;
    assign key = {pc_write, pc_src, mem_write, reg_write, mem_to_reg, instr_done, illegal};
    assign act_all = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg, pc_src,
                      alu_src_a, alu_src_b, alu_op, instr_done, illegal, state};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input logic [6:0] o, input bit z, input bit m);
        @(negedge clk);
        reset = r; opcode = o; zero = z; mem_ready = m;
        #1;
    endtask

    typedef struct {
        bit         rst;
        logic [6:0] op;
        bit         z;
        bit         mr;
        logic [3:0] st;
        logic [6:0] e;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit r, input logic [6:0] o, input bit z, input bit m,
                       input logic [3:0] s, input logic [6:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.z = z; v.mr = m; v.st = s; v.e = e;
        tbl.push_back(v);
    endtask

    // Expected full output vector for a given spec-level state number.
    function automatic logic [19:0] ref_out(input int st, input bit z, input bit mr, input bit rst);
        logic pcw, irw, io, mrd, mwr, rw, mtr, ps, done, ill;
        logic [1:0] a, b, op;
        {pcw, irw, io, mrd, mwr, rw, mtr, ps, done, ill} = '0;
        a = 2'b00; b = 2'b00; op = 2'b00;
        case (st)
            0:  begin mrd = 1; b = 2'b01; pcw = mr; irw = mr; end
            1:  b = 2'b10;
            2:  begin a = 2'b01; b = 2'b10; end
            3:  begin io = 1; mrd = 1; end
            4:  begin rw = 1; mtr = 1; done = 1; end
            5:  begin io = 1; mwr = 1; done = mr; end
            6:  begin a = 2'b01; op = 2'b10; end
            7:  begin a = 2'b01; b = 2'b10; op = 2'b11; end
            8:  begin rw = 1; done = 1; end
            9:  begin a = 2'b01; op = 2'b01; ps = 1; pcw = z; done = 1; end
            10: begin b = 2'b11; rw = 1; pcw = 1; ps = 1; done = 1; end
            11: ill = 1;
            default: ;
        endcase
        if (rst) {pcw, irw, mrd, mwr, rw, done, ill} = '0;
        return {pcw, irw, io, mrd, mwr, rw, mtr, ps, a, b, op, done, ill, st[3:0]};
    endfunction

    int         m_st;
    int         plan[$];
    bit         r, z, mr;
    logic [6:0] rop;
    int         dones;

    initial begin
        // Directed table: {reset, opcode, zero, mem_ready} -> {state, key strobes}
        add(1, 7'h33, 0, 1, 0, 7'b0000000);
        // R-type, zero wait states
        add(0, 7'h33, 0, 1, 0, 7'b1000000);
        add(0, 7'h33, 0, 1, 1, 7'b0000000);
        add(0, 7'h33, 0, 1, 6, 7'b0000000);
        add(0, 7'h33, 0, 1, 8, 7'b0001010);
        // Load with two wait cycles in MEMRD
        add(0, 7'h03, 0, 1, 0, 7'b1000000);
        add(0, 7'h03, 0, 1, 1, 7'b0000000);
        add(0, 7'h03, 0, 1, 2, 7'b0000000);
        add(0, 7'h03, 0, 0, 3, 7'b0000000);
        add(0, 7'h03, 0, 0, 3, 7'b0000000);
        add(0, 7'h03, 0, 1, 3, 7'b0000000);
        add(0, 7'h03, 0, 1, 4, 7'b0001110);
        // Branch taken / not taken
        add(0, 7'h63, 1, 1, 0, 7'b1000000);
        add(0, 7'h63, 1, 1, 1, 7'b0000000);
        add(0, 7'h63, 1, 1, 9, 7'b1100010);
        add(0, 7'h63, 0, 1, 0, 7'b1000000);
        add(0, 7'h63, 0, 1, 1, 7'b0000000);
        add(0, 7'h63, 0, 1, 9, 7'b0100010);
        // Store with one wait cycle
        add(0, 7'h23, 0, 1, 0, 7'b1000000);
        add(0, 7'h23, 0, 1, 1, 7'b0000000);
        add(0, 7'h23, 0, 1, 2, 7'b0000000);
        add(0, 7'h23, 0, 0, 5, 7'b0010000);
        add(0, 7'h23, 0, 1, 5, 7'b0010010);
        // Store interrupted by reset mid-wait
        add(0, 7'h23, 0, 1, 0, 7'b1000000);
        add(0, 7'h23, 0, 1, 1, 7'b0000000);
        add(0, 7'h23, 0, 1, 2, 7'b0000000);
        add(0, 7'h23, 0, 0, 5, 7'b0010000);
        add(1, 7'h23, 0, 0, 5, 7'b0000000);
        add(0, 7'h23, 0, 0, 0, 7'b0000000);

        drive(1, 7'h00, 0, 0);
        drive(1, 7'h00, 0, 0);
        dones = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].mr);
            chk($sformatf("tbl%0d.state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d.strobes", i), 32'(key), 32'(tbl[i].e));
            if (i >= 1 && i <= 4) dones += int'(instr_done);
        end
        chk("rtype.done_count", 32'(dones), 32'd1);

        // Illegal opcode: trap held, then cleared by reset
        drive(0, 7'h7F, 0, 1); chk("trap.fetch", 32'(state), 32'd0);
        drive(0, 7'h7F, 0, 1); chk("trap.decode", 32'(state), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(0, 7'h7F, 0, $urandom_range(0, 1));
            chk($sformatf("trap.hold%0d", i), 32'({state, illegal, mem_read, pc_write}), 32'({4'd11, 1'b1, 1'b0, 1'b0}));
        end
        drive(1, 7'h7F, 0, 1); chk("trap.rst_ill", 32'({illegal, instr_done}), 32'd0);
        drive(0, 7'h00, 0, 0);
        chk("trap.after_rst", 32'({state, illegal, mem_read}), 32'({4'd0, 1'b0, 1'b1}));

        // JAL opcode, macro-dependent
        drive(0, 7'h6F, 0, 1); chk("jal.fetch", 32'(state), 32'd0);
        drive(0, 7'h6F, 0, 1); chk("jal.decode", 32'(state), 32'd1);
        drive(0, 7'h6F, 0, 0);
`ifdef MULTICYCLE_CTRL_JAL_EN
        chk("jal.state", 32'(state), 32'd10);
        chk("jal.strobes", 32'(key), 32'(7'b1101010));
        chk("jal.alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'(6'b001100));
        drive(0, 7'h6F, 0, 0); chk("jal.back", 32'(state), 32'd0);
`else
        chk("jal.trap", 32'({state, illegal}), 32'({4'd11, 1'b1}));
        drive(1, 7'h6F, 0, 0);
        drive(0, 7'h00, 0, 0); chk("jal.rst", 32'(state), 32'd0);
`endif

        // Randomized run against a route-based model
        m_st = 0;
        rop = 7'h00;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 49) == 0) || (m_st == 11 && $urandom_range(0, 3) == 0);
            z  = 1'($urandom_range(0, 1));
            mr = ($urandom_range(0, 2) != 0);
            if (m_st == 0) begin
                case ($urandom_range(0, 7))
                    0: rop = 7'h03;
                    1: rop = 7'h23;
                    2: rop = 7'h33;
                    3: rop = 7'h13;
                    4: rop = 7'h63;
                    5: rop = 7'h6F;
                    default: rop = 7'($urandom);
                endcase
            end
            drive(r, rop, z, mr);
            chk("rand.outputs", 32'(act_all), 32'(ref_out(m_st, z, mr, r)));
            if (r) begin
                m_st = 0;
                plan.delete();
            end else begin
                case (m_st)
                    0: if (mr) m_st = 1;
                    1: begin
                        case (rop)
                            7'h03: plan = '{2, 3, 4};
                            7'h23: plan = '{2, 5};
                            7'h33: plan = '{6, 8};
                            7'h13: plan = '{7, 8};
                            7'h63: plan = '{9};
`ifdef MULTICYCLE_CTRL_JAL_EN
                            7'h6F: plan = '{10};
`endif
                            default: plan = '{11};
                        endcase
                        m_st = plan.pop_front();
                    end
                    3, 5: if (mr) m_st = (plan.size() != 0) ? plan.pop_front() : 0;
                    11: ;
                    default: m_st = (plan.size() != 0) ? plan.pop_front() : 0;
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: opcode  in  7  instruction[6:0] from the instruction register.
REQ-004 SHALL have ports: zero  in  1  ALU zero flag.
REQ-005 SHALL have ports: mem_ready  in  1  unified memory completion handshake.
REQ-006 SHALL have ports: pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg, pc_src  out  1 each  datapath strobes and selects (iord=1 selects data address).
REQ-007 SHALL have ports: alu_src_a  out  2  (00 PC, 01 rs1); alu_src_b  out  2  (00 rs2, 01 const 4, 10 imm, 11 zero); alu_op  out  2  (00 add, 01 sub, 10 R-funct, 11 I-funct).
REQ-008 SHALL have ports: state  out  4  current state encoding; instr_done  out  1  retire pulse; illegal  out  1  sticky trap flag.

Function
REQ-009 SHALL use Moore states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=11; codes 12-15 unreachable and SHALL recover to FETCH.
REQ-010 SHALL have all outputs not listed for a state at 0.
REQ-011 FETCH SHALL drive mem_read=1, iord=0, a=00, b=01, op=00, and SHALL assert pc_write=ir_write=mem_ready (combinational). It SHALL hold until mem_ready=1 and then go to DECODE.
REQ-012 DECODE SHALL drive a=00, b=10, op=00 to precompute the branch target, and SHALL go next by opcode: 0000011/0100011->MEMADR; 0110011->EXEC_R; 0010011->EXEC_I; 1100011->BRANCH; 1101111->JAL (macro-dependent); any other->TRAP.
REQ-013 MEMADR SHALL drive a=01, b=10, op=00, and SHALL go next to MEMRD for load or MEMWR for store (opcode re-sampled).
REQ-014 MEMRD SHALL drive iord=1, mem_read=1, hold until mem_ready, and then go to MEMWB.
REQ-015 MEMWB SHALL drive reg_write=1, mem_to_reg=1, instr_done=1, and then go to FETCH.
REQ-016 MEMWR SHALL drive iord=1, mem_write=1, hold until mem_ready, and go to FETCH with instr_done=1 in the mem_ready cycle.
REQ-017 EXEC_R SHALL drive a=01, b=00, op=10; EXEC_I SHALL drive a=01, b=10, op=11; both SHALL go next to ALUWB.
REQ-018 ALUWB SHALL drive reg_write=1, mem_to_reg=0, instr_done=1, and then go to FETCH.
REQ-019 BRANCH SHALL drive a=01, b=00, op=01, pc_src=1, pc_write=zero, instr_done=1, and then go to FETCH.
REQ-020 TRAP SHALL assert illegal=1 with all strobes 0, and SHALL remain in TRAP until reset.
REQ-021 mem_ready SHALL be ignored outside FETCH/MEMRD/MEMWR; there is no timeout, and a wait holds indefinitely.
REQ-022 instr_done SHALL be exactly one cycle per retired instruction; minimum latencies are R/I/load-wb 4/4/5 cycles, store 4, branch 3 (zero wait states).

Reset
REQ-023 While reset=1, the block SHALL force pc_write, ir_write, mem_read, mem_write, reg_write, and instr_done to 0, and illegal to 0.
REQ-024 On the clock edge with reset=1, state SHALL become FETCH from any state, including mid-wait in MEMRD/MEMWR and TRAP.
REQ-025 After reset deassertion, the first cycle SHALL be FETCH with mem_read=1.

Configuration
REQ-026 Macro MULTICYCLE_CTRL_JAL_EN: when defined, opcode 1101111 SHALL go to JAL, which drives a=00, b=11, op=00, reg_write=1, pc_write=1, pc_src=1, instr_done=1, and then goes to FETCH (3 cycles). When undefined, opcode 1101111 SHALL go to TRAP and state 10 SHALL be unreachable.

Verification
REQ-027 Bench SHALL cover: opcode=0110011, mem_ready=1 constant -> state 0,1,6,8,0; reg_write=1 only in state 8; instr_done once.
REQ-028 Bench SHALL cover: opcode=0000011, mem_ready low for 2 cycles in MEMRD -> state 0,1,2,3,3,3,4,0; reg_write=mem_to_reg=1 in state 4.
REQ-029 Bench SHALL cover: opcode=1100011, zero=1 -> pc_write=1, pc_src=1 in BRANCH; repeat with zero=0 -> pc_write=0.
REQ-030 Bench SHALL cover: opcode=7'h7F -> TRAP, illegal=1 held 10 cycles; reset pulse -> state 0, illegal=0.
REQ-031 Bench SHALL cover: reset asserted in MEMWR with mem_ready=0 -> mem_write=0 that cycle, state=0 next cycle.
REQ-032 Bench SHALL cover: opcode=1101111 -> JAL (state 10, pc_write=1) with macro; TRAP (state 11) without macro.
